hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives STALL/FLUSH of the IF/ID, ID/EXE and EXE/MEM pipeline registers and the PC write enable.
- Detects load-use hazards against the ID/EXE stage and flushes on taken branches resolved in ID.
- Freezes the whole pipeline while data memory is not ready, with timeout detection and saturating performance counters.

---
 rtl/hazard_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: detects load-use hazards and taken branches in ID, freezes the
// pipeline while data memory is busy, and traps into ERROR after a memory
// timeout. It also keeps saturating stall and flush performance counters.
//
// Ports:
//   CLOCK, RESET          rising-edge clock, synchronous active-high reset
//   ID_Rs/ID_Rt/ID_Uses*  source operands of the instruction in ID
//   IDEXE_*               load/writeback info of the instruction in EXE
//   BranchTaken           branch/jump resolved taken in ID
//   MemReq, MemReady      MEM stage access handshake
//   PCWrite, STALL_*, FLUSH_*  pipeline control (combinational, Mealy)
//   MemTimeout            sticky timeout flag
//   State_OUT             0 RUN, 1 MEMWAIT, 2 ERROR
//   StallCycles, FlushCount  saturating performance counters
module hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             IDEXE_MemRead,
  input  logic [4:0]       IDEXE_WriteRegister,
  input  logic             IDEXE_WriteEnable,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEXE,
  output logic             FLUSH_IDEXE,
  output logic             STALL_EXEMEM,
  output logic             MemTimeout,
  output logic [1:0]       State_OUT,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] waitCount;
  logic              loadUse;
  logic              memWait;
  logic              freeze;

  assign State_OUT = state;

  always_comb begin
    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    loadUse = IDEXE_MemRead && IDEXE_WriteEnable && (IDEXE_WriteRegister != 5'd0) &&
              ((ID_UsesRs && (ID_Rs == IDEXE_WriteRegister)) ||
               (ID_UsesRt && (ID_Rt == IDEXE_WriteRegister)));
    memWait = MemReq && !MemReady;
    // In MEMWAIT the release cycle (memWait low) is not frozen, so freeze
    // depends only on memWait outside ERROR.
    freeze  = (state == ERROR) || memWait;

    PCWrite      = 1'b1;
    STALL_IFID   = 1'b0;
    FLUSH_IFID   = 1'b0;
    STALL_IDEXE  = 1'b0;
    FLUSH_IDEXE  = 1'b0;
    STALL_EXEMEM = 1'b0;

    if (RESET) begin
      PCWrite     = 1'b0;
      FLUSH_IFID  = 1'b1;
      FLUSH_IDEXE = 1'b1;
    end else if (freeze) begin
      PCWrite      = 1'b0;
      STALL_IFID   = 1'b1;
      STALL_IDEXE  = 1'b1;
      STALL_EXEMEM = 1'b1;
    end else if (loadUse) begin
      // One bubble: hold IF/ID and PC, let the load advance, and insert a
      // nop into ID/EXE. A same-cycle branch used stale operands, so it is dropped.
      PCWrite     = 1'b0;
      STALL_IFID  = 1'b1;
      FLUSH_IDEXE = 1'b1;
    end else if (BranchTaken) begin
      FLUSH_IFID = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= RUN;
      waitCount   <= '0;
      MemTimeout  <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (!PCWrite && (StallCycles != {CNT_W{1'b1}})) begin
        StallCycles <= StallCycles + 1'b1;
      end
      if ((FLUSH_IFID || FLUSH_IDEXE) && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + 1'b1;
      end

      case (state)
        RUN: begin
          if (memWait) begin
            state     <= MEMWAIT;
            waitCount <= WAIT_W'(1);
          end
        end
        MEMWAIT: begin
          if (!memWait) begin
            state     <= RUN;
            waitCount <= '0;
          end else if (waitCount == TIMEOUT_VAL) begin
            state      <= ERROR;
            MemTimeout <= 1'b1;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state     <= RUN;
          waitCount <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [4:0] ID_Rs, ID_Rt;
  logic       ID_UsesRs, ID_UsesRt;
  logic       IDEXE_MemRead;
  logic [4:0] IDEXE_WriteRegister;
  logic       IDEXE_WriteEnable;
  logic       BranchTaken;
  logic       MemReq, MemReady;
  logic       PCWrite, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM;
  logic       MemTimeout;
  logic [1:0] State_OUT;
  logic [3:0] StallCycles, FlushCount;

  // Control word order: {PCWrite, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM}
  localparam logic [5:0] C_RST  = 6'b001010;
  localparam logic [5:0] C_FRZ  = 6'b010101;
  localparam logic [5:0] C_LU   = 6'b010010;
  localparam logic [5:0] C_BR   = 6'b101000;
  localparam logic [5:0] C_IDLE = 6'b100000;

  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [1:0] st;
    logic       to;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .IDEXE_MemRead(IDEXE_MemRead), .IDEXE_WriteRegister(IDEXE_WriteRegister),
    .IDEXE_WriteEnable(IDEXE_WriteEnable), .BranchTaken(BranchTaken),
    .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(PCWrite), .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID),
    .STALL_IDEXE(STALL_IDEXE), .FLUSH_IDEXE(FLUSH_IDEXE), .STALL_EXEMEM(STALL_EXEMEM),
    .MemTimeout(MemTimeout), .State_OUT(State_OUT),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 CLOCK = ~CLOCK;

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  always @(negedge CLOCK) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      logic [5:0] ctl;
      e = sbQ.pop_front();
      ctl = {PCWrite, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM};
      vectors++;
      if (ctl !== e.ctl || State_OUT !== e.st || MemTimeout !== e.to ||
          StallCycles !== e.sc || FlushCount !== e.fc) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b st=%0d to=%b sc=%0d fc=%0d, expected ctl=%b st=%0d to=%b sc=%0d fc=%0d",
                 e.name, ctl, State_OUT, MemTimeout, StallCycles, FlushCount,
                 e.ctl, e.st, e.to, e.sc, e.fc);
      end
    end
  end

  task automatic clearIn();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    IDEXE_MemRead = 1'b0; IDEXE_WriteRegister = 5'd0; IDEXE_WriteEnable = 1'b0;
    BranchTaken = 1'b0; MemReq = 1'b0; MemReady = 1'b0;
  endtask

  task automatic setLoad(input int wreg, input int rs, input int rt, input logic uRs, input logic uRt);
    clearIn();
    IDEXE_MemRead = 1'b1; IDEXE_WriteEnable = 1'b1;
    IDEXE_WriteRegister = 5'(wreg);
    ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UsesRs = uRs; ID_UsesRt = uRt;
  endtask

  task automatic apply(input string nm, input logic [5:0] ctl, input int st, input logic to,
                       input int sc, input int fc);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.st = 2'(st); e.to = to; e.sc = 4'(sc); e.fc = 4'(fc);
    sbQ.push_back(e);
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    clearIn();
    @(posedge CLOCK);
    #1;
    apply("reset1", C_RST, 0, 0, 0, 0);
    apply("reset2", C_RST, 0, 0, 0, 0);
    RESET = 1'b0;
    apply("idle0", C_IDLE, 0, 0, 0, 0);

    setLoad(5, 0, 5, 0, 1);       apply("lu_rt", C_LU, 0, 0, 0, 0);
    clearIn();                    apply("after_lu", C_IDLE, 0, 0, 1, 1);
    setLoad(0, 0, 0, 0, 1);       apply("lu_r0", C_IDLE, 0, 0, 1, 1);
    setLoad(7, 7, 0, 1, 0);       apply("lu_rs", C_LU, 0, 0, 1, 1);
    setLoad(5, 0, 5, 0, 1); BranchTaken = 1'b1;
                                  apply("lu_branch", C_LU, 0, 0, 2, 2);
    clearIn(); BranchTaken = 1'b1; apply("branch", C_BR, 0, 0, 3, 3);
    clearIn();                    apply("idle1", C_IDLE, 0, 0, 3, 4);
    setLoad(5, 0, 5, 0, 0);       apply("lu_nouse", C_IDLE, 0, 0, 3, 4);
    setLoad(5, 0, 5, 0, 1); IDEXE_WriteEnable = 1'b0;
                                  apply("lu_nowe", C_IDLE, 0, 0, 3, 4);

    clearIn(); MemReq = 1'b1;
    apply("mw1", C_FRZ, 0, 0, 3, 4);
    apply("mw2", C_FRZ, 1, 0, 4, 4);
    apply("mw3", C_FRZ, 1, 0, 5, 4);
    MemReady = 1'b1;              apply("mw_release", C_IDLE, 1, 0, 6, 4);
    clearIn();                    apply("mw_run", C_IDLE, 0, 0, 6, 4);
    setLoad(5, 0, 5, 0, 1); MemReq = 1'b1;
                                  apply("mw_lu", C_FRZ, 0, 0, 6, 4);
    MemReq = 1'b0;                apply("release_lu", C_LU, 1, 0, 7, 4);
    clearIn(); MemReq = 1'b1; MemReady = 1'b1;
                                  apply("zero_wait", C_IDLE, 0, 0, 8, 5);

    MemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("timeout%0d", i), C_FRZ, (i == 0) ? 0 : 1, 0, 8 + i, 5);
    end
    apply("error", C_FRZ, 2, 1, 13, 5);
    MemReady = 1'b1;              apply("error_rdy", C_FRZ, 2, 1, 14, 5);
    clearIn(); BranchTaken = 1'b1; apply("error_br", C_FRZ, 2, 1, 15, 5);
    RESET = 1'b1;                 apply("reset_err", C_RST, 2, 1, 15, 5);
    RESET = 1'b0; clearIn();      apply("post_reset", C_IDLE, 0, 0, 0, 0);

    setLoad(5, 0, 5, 0, 1);
    for (int i = 0; i < 20; i++) begin
      apply($sformatf("sat%0d", i), C_LU, 0, 0, (i > 15) ? 15 : i, (i > 15) ? 15 : i);
    end
    clearIn();                    apply("sat_hold", C_IDLE, 0, 0, 15, 15);
    MemReq = 1'b1;                apply("mw_pre_reset", C_FRZ, 0, 0, 15, 15);
    RESET = 1'b1;                 apply("reset_mw", C_RST, 1, 0, 15, 15);
    RESET = 1'b0; clearIn();      apply("post_reset2", C_IDLE, 0, 0, 0, 0);

    for (int k = 0; k < 5 && sbQ.size() > 0; k++) @(negedge CLOCK);
    if (sbQ.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
